core_set: RTL and testbench
===========================

Name: core_set

Overview:
Address/transfer sequencer for the image-rotation engine. It walks a WxH 8-bit-pixel source image in 4x4 tiles and issues single-byte DMA reads of each tile into a 16-entry tile buffer. It then issues single-byte DMA writes of the same pixels to their rotated positions in the destination image. It sits between the register/control block (size, angle, start) and the AHB DMA master, which accepts one transfer per cycle while I_DMA_READY is high.

Parameters:
SRC_BASE, 32'h0000_0000, byte base address of source image
DST_BASE, 32'h0001_0000, byte base address of destination image

Ports:
I_HCLK  in  1  clock, rising edge
I_HRESET_N  in  1  asynchronous active-low reset
I_START  in  1  one-cycle start pulse, honoured only in IDLE
I_WIDTH  in  16  source width W in pixels
I_HEIGHT  in  16  source height H in pixels
I_DIRECTION  in  1  0 = clockwise, 1 = counter-clockwise
I_DEGREES  in  3  0 = 0°, 1 = 90°, 2 = 180°, 3 = 270°, 4..7 treated as 0°
I_DMA_READY  in  1  DMA accepts the currently presented transfer at this edge
O_ADDR  out  32  byte address of current transfer
O_SIZE  out  3  HSIZE of transfer, constant 3'b000 (byte)
O_WRITE  out  1  0 = read (source to tile buffer), 1 = write (tile buffer to destination)
O_COUNT  out  5  tile-buffer index of current pixel, r*4+c (0..15, bit4 always 0)
O_BUSY  out  1  operation in progress

Behaviour:
- Interface: one clock I_HCLK; reset I_HRESET_N is asynchronous and active-low.
- Reset (asynchronous, any state, including mid-operation): state IDLE; O_ADDR=0, O_SIZE=3'b000, O_WRITE=0, O_COUNT=0, O_BUSY=0. The operation in progress is aborted with no further transfers.
- Rotation k (quarter turns clockwise):
  - k = I_DEGREES[1:0] if I_DEGREES<4, else 0.
  - If I_DIRECTION=1, k = (4-k) mod 4.
- Destination mapping for pixel (x,y): dest = DST_BASE + yd*Wd + xd.
  - k=0: (x,y), Wd=W.
  - k=1: (H-1-y, x), Wd=H.
  - k=2: (W-1-x, H-1-y), Wd=W.
  - k=3: (y, W-1-x), Wd=H.
- Source address: SRC_BASE + y*W + x. Use 32-bit arithmetic; products are 16x16 unsigned.
- States:
  - IDLE -> READ: I_START=1 while W!=0 and H!=0. W, H and k are latched at this edge; later input changes are ignored until the next start.
  - READ -> WRITE: after the last read of the tile is accepted.
  - WRITE -> READ: after the last write, if more tiles remain.
  - WRITE -> IDLE: after the last write of the last tile.
- Start with W=0 or H=0: ignored, stays IDLE. I_START outside IDLE: ignored.
- Tiles are traversed row-major: tx = 0,4,8,... then ty = 0,4,8,...
  - Tile size tw = min(4, W-tx), th = min(4, H-ty).
  - Edge tiles are partial (e.g. W=62 gives last tw=2).
- Within each tile, both READ and WRITE iterate r = 0..th-1 (outer) and c = 0..tw-1 (inner).
  - Pixel coordinates: x = tx+c, y = ty+r.
  - O_COUNT = r*4+c.
- Timing:
  - Outputs are registered. The first read (x=0, y=0, O_WRITE=0) and O_BUSY=1 appear the cycle after the start edge.
  - A transfer completes at an edge where I_DMA_READY=1. The next transfer's outputs appear the following cycle.
  - With I_DMA_READY held high, there is one transfer per cycle with no gaps, including READ<->WRITE boundaries.
  - While I_DMA_READY=0, all outputs hold.
- Completion: the cycle after the final write is accepted, O_BUSY=0 and O_ADDR/O_WRITE/O_COUNT return to 0.
- Total accepted transfers per operation: 2*W*H (W*H reads, W*H writes).
- A new I_START is accepted immediately after returning to IDLE.

Test Plan:
- Reset, W=8, H=8, k=0, start, DMA_READY high 2 cycles later -> 4 tiles, 128 transfers.
  - First read: O_ADDR=SRC_BASE, O_COUNT=0.
  - First write: O_ADDR=DST_BASE.
  - Tile 2 first read: O_ADDR=SRC_BASE+4.
  - O_BUSY falls after the 128th acceptance.
- W=62, H=63, k=0 -> 16x16 tiles.
  - Last tile tw=2, th=3, 6 reads + 6 writes.
  - Final write O_ADDR=DST_BASE+3905.
  - 7812 total transfers.
- W=123, H=5, k=0 -> tile rows of th=4 then th=1, last tw=3; final read O_ADDR=SRC_BASE+614.
- W=32, H=24, I_DEGREES=1, dir=0 -> first write O_ADDR=DST_BASE+23.
  - Same setup with dir=1 (k=3): first write O_ADDR=DST_BASE+31*24.
- Stall and control cases:
  - Toggle I_DMA_READY low mid-burst -> O_ADDR/O_COUNT/O_WRITE frozen; sequence resumes without skipping.
  - I_START while busy -> ignored.
  - Reset mid-read -> all outputs 0, O_BUSY=0 asynchronously.
- I_WIDTH=0 with I_START -> O_BUSY stays 0, no transfers; I_DEGREES=6 behaves as 0°.

Source files
------------

// File: rtl/core_set.sv
// Purpose: walks a WxH byte image in 4x4 tiles, issuing DMA byte reads into a tile buffer, then rotated writes out of it.
// Latency: first transfer presented the cycle after the start edge; then one transfer per accepted cycle, no bubbles.
// Backpressure: every output and all internal state hold while I_DMA_READY is low.
module core_set #(
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h0001_0000
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic        I_START,
    input  logic [15:0] I_WIDTH,
    input  logic [15:0] I_HEIGHT,
    input  logic        I_DIRECTION,
    input  logic [2:0]  I_DEGREES,
    input  logic        I_DMA_READY,
    output logic [31:0] O_ADDR,
    output logic [2:0]  O_SIZE,
    output logic        O_WRITE,
    output logic [4:0]  O_COUNT,
    output logic        O_BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state;
    state_t      nxt_state;

    // Operation parameters captured at the start edge.
    logic [15:0] w_q;
    logic [15:0] h_q;
    logic [1:0]  k_q;

    // Current tile origin and pixel position inside the tile.
    logic [15:0] tx;
    logic [15:0] ty;
    logic [1:0]  r;
    logic [1:0]  c;
    logic [15:0] nxt_tx;
    logic [15:0] nxt_ty;
    logic [1:0]  nxt_r;
    logic [1:0]  nxt_c;

    logic [1:0]  k_in;
    logic        start_ok;
    logic        advance;
    logic [15:0] rem_w;
    logic [15:0] rem_h;
    logic [1:0]  tw_last;
    logic [1:0]  th_last;
    logic        last_col;
    logic        last_row;
    logic        last_pix;
    logic        more_cols;
    logic        more_rows;
    logic        last_tile;

    // Parameters used to build the next address: live inputs on the start
    // edge, latched copies for the rest of the operation.
    logic [15:0] cur_w;
    logic [15:0] cur_h;
    logic [1:0]  cur_k;

    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] xd;
    logic [15:0] yd;
    logic [15:0] wd;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] nxt_addr;
    logic        nxt_write;
    logic [4:0]  nxt_count;
    logic        nxt_busy;

    assign O_SIZE = 3'b000;

    // Quarter-turns clockwise; out-of-range angles mean no rotation,
    // counter-clockwise is the modular negation.
    always_comb begin
        k_in = I_DEGREES[2] ? 2'd0 : I_DEGREES[1:0];
        if (I_DIRECTION) begin
            k_in = 2'd0 - k_in;
        end
    end

    assign start_ok = (state == IDLE) && I_START && (I_WIDTH != 16'd0) && (I_HEIGHT != 16'd0);
    assign advance  = (state != IDLE) && I_DMA_READY;

    // Tile extent: full 4 pixels unless clipped by the right/bottom edge.
    always_comb begin
        rem_w     = w_q - tx;
        rem_h     = h_q - ty;
        tw_last   = (rem_w >= 16'd4) ? 2'd3 : (rem_w[1:0] - 2'd1);
        th_last   = (rem_h >= 16'd4) ? 2'd3 : (rem_h[1:0] - 2'd1);
        last_col  = (c == tw_last);
        last_row  = (r == th_last);
        last_pix  = last_col && last_row;
        more_cols = ({1'b0, tx} + 17'd4) < {1'b0, w_q};
        more_rows = ({1'b0, ty} + 17'd4) < {1'b0, h_q};
        last_tile = !more_cols && !more_rows;
    end

    // State register.
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state: a tile is read fully, then written fully, then the next tile follows.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE: begin
                if (start_ok) nxt_state = READ;
            end
            READ: begin
                if (advance && last_pix) nxt_state = WRITE;
            end
            WRITE: begin
                if (advance && last_pix) nxt_state = last_tile ? IDLE : READ;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Next pixel position: column inner, row outer, tiles row-major after each write pass.
    always_comb begin
        nxt_tx = tx;
        nxt_ty = ty;
        nxt_r  = r;
        nxt_c  = c;
        if (start_ok) begin
            nxt_tx = 16'd0;
            nxt_ty = 16'd0;
            nxt_r  = 2'd0;
            nxt_c  = 2'd0;
        end else if (advance) begin
            if (!last_col) begin
                nxt_c = c + 2'd1;
            end else if (!last_row) begin
                nxt_c = 2'd0;
                nxt_r = r + 2'd1;
            end else begin
                nxt_c = 2'd0;
                nxt_r = 2'd0;
                if (state == WRITE) begin
                    if (more_cols) begin
                        nxt_tx = tx + 16'd4;
                    end else if (more_rows) begin
                        nxt_tx = 16'd0;
                        nxt_ty = ty + 16'd4;
                    end else begin
                        nxt_tx = 16'd0;
                        nxt_ty = 16'd0;
                    end
                end
            end
        end
    end

    // Output decode: address of the transfer that will be presented next cycle.
    always_comb begin
        cur_w = (state == IDLE) ? I_WIDTH  : w_q;
        cur_h = (state == IDLE) ? I_HEIGHT : h_q;
        cur_k = (state == IDLE) ? k_in     : k_q;
        x     = nxt_tx + {14'd0, nxt_c};
        y     = nxt_ty + {14'd0, nxt_r};
        xd    = x;
        yd    = y;
        wd    = cur_w;
        case (cur_k)
            2'd1: begin
                xd = cur_h - 16'd1 - y;
                yd = x;
                wd = cur_h;
            end
            2'd2: begin
                xd = cur_w - 16'd1 - x;
                yd = cur_h - 16'd1 - y;
                wd = cur_w;
            end
            2'd3: begin
                xd = y;
                yd = cur_w - 16'd1 - x;
                wd = cur_h;
            end
            default: begin
                xd = x;
                yd = y;
                wd = cur_w;
            end
        endcase
        src_addr  = SRC_BASE + ({16'd0, y}  * {16'd0, cur_w}) + {16'd0, x};
        dst_addr  = DST_BASE + ({16'd0, yd} * {16'd0, wd})    + {16'd0, xd};
        nxt_addr  = 32'd0;
        nxt_write = 1'b0;
        nxt_count = 5'd0;
        nxt_busy  = 1'b0;
        if (nxt_state == READ) begin
            nxt_addr  = src_addr;
            nxt_count = {1'b0, nxt_r, nxt_c};
            nxt_busy  = 1'b1;
        end else if (nxt_state == WRITE) begin
            nxt_addr  = dst_addr;
            nxt_write = 1'b1;
            nxt_count = {1'b0, nxt_r, nxt_c};
            nxt_busy  = 1'b1;
        end
    end

    // Position, latched parameters and registered outputs.
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            w_q     <= 16'd0;
            h_q     <= 16'd0;
            k_q     <= 2'd0;
            tx      <= 16'd0;
            ty      <= 16'd0;
            r       <= 2'd0;
            c       <= 2'd0;
            O_ADDR  <= 32'd0;
            O_WRITE <= 1'b0;
            O_COUNT <= 5'd0;
            O_BUSY  <= 1'b0;
        end else begin
            if (start_ok) begin
                w_q <= I_WIDTH;
                h_q <= I_HEIGHT;
                k_q <= k_in;
            end
            tx      <= nxt_tx;
            ty      <= nxt_ty;
            r       <= nxt_r;
            c       <= nxt_c;
            O_ADDR  <= nxt_addr;
            O_WRITE <= nxt_write;
            O_COUNT <= nxt_count;
            O_BUSY  <= nxt_busy;
        end
    end

endmodule

// File: tb/tb_core_set.sv
// Purpose: randomized scoreboard bench for the tile rotation sequencer.
// Latency: expects first transfer one cycle after start, one per accepted cycle.
// Backpressure: random DMA ready; presented transfer must stay on the queue head until accepted.
module tb_core_set;

    localparam logic [31:0] SRC = 32'h0000_0000;
    localparam logic [31:0] DST = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] width;
    logic [15:0] height;
    logic        dir;
    logic [2:0]  deg;
    logic        ready;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [4:0]  count;
    logic        busy;

    always #5 clk = ~clk;

    core_set #(.SRC_BASE(SRC), .DST_BASE(DST)) dut (
        .I_HCLK      (clk),
        .I_HRESET_N  (rst_n),
        .I_START     (start),
        .I_WIDTH     (width),
        .I_HEIGHT    (height),
        .I_DIRECTION (dir),
        .I_DEGREES   (deg),
        .I_DMA_READY (ready),
        .O_ADDR      (addr),
        .O_SIZE      (size),
        .O_WRITE     (wr),
        .O_COUNT     (count),
        .O_BUSY      (busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [4:0]  count;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    bit    op_active = 1'b0;
    bit    expect_idle = 1'b0;
    int    ready_pct = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    // Reference: the rotation expressed directly as coordinate formulas.
    function automatic logic [31:0] dest_of(input longint x, input longint y,
                                            input longint w, input longint h, input int k);
        longint xd, yd, wd;
        case (k)
            1:       begin xd = h - 1 - y; yd = x;         wd = h; end
            2:       begin xd = w - 1 - x; yd = h - 1 - y; wd = w; end
            3:       begin xd = y;         yd = w - 1 - x; wd = h; end
            default: begin xd = x;         yd = y;         wd = w; end
        endcase
        return 32'(longint'(DST) + yd * wd + xd);
    endfunction

    task automatic push_op(input int w, input int h, input int dg, input bit d);
        int k;
        xfer_t e;
        k = (dg < 4) ? dg : 0;
        if (d) k = (4 - k) % 4;
        for (int ty = 0; ty < h; ty += 4) begin
            for (int tx = 0; tx < w; tx += 4) begin
                int tw, th;
                tw = (w - tx < 4) ? w - tx : 4;
                th = (h - ty < 4) ? h - ty : 4;
                for (int rr = 0; rr < th; rr++)
                    for (int cc = 0; cc < tw; cc++) begin
                        e.addr  = 32'(longint'(SRC) + longint'(ty + rr) * w + (tx + cc));
                        e.wr    = 1'b0;
                        e.count = 5'(rr * 4 + cc);
                        exp_q.push_back(e);
                    end
                for (int rr = 0; rr < th; rr++)
                    for (int cc = 0; cc < tw; cc++) begin
                        e.addr  = dest_of(tx + cc, ty + rr, w, h, k);
                        e.wr    = 1'b1;
                        e.count = 5'(rr * 4 + cc);
                        exp_q.push_back(e);
                    end
            end
        end
    endtask

    // Monitor: compares the presented transfer against the queue head every busy cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (expect_idle) begin
                check("idle_after_done", {busy, addr, wr, count}, 64'd0);
                expect_idle = 1'b0;
            end else if (op_active) begin
                check("busy_during_op", busy, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 1, 0);
                    op_active = 1'b0;
                end else begin
                    check("xfer", {addr, wr, count, size},
                          {exp_q[0].addr, exp_q[0].wr, exp_q[0].count, 3'b000});
                    if (ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            op_active   = 1'b0;
                            expect_idle = 1'b1;
                        end
                    end
                end
            end else begin
                check("idle_busy", busy, 0);
            end
        end
    end

    // DMA ready driver.
    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready = ($urandom_range(99) < ready_pct);
        end
    end

    // One operation: start pulse, garbage on the inputs afterwards, optional
    // ignored start pulse and optional mid-operation reset.
    task automatic run_op(input int w, input int h, input int dg, input bit d,
                          input int rpct, input bit poke, input int reset_at);
        int n;
        int budget;
        ready_pct = rpct;
        @(posedge clk);
        #1;
        width  = 16'(w);
        height = 16'(h);
        deg    = 3'(dg);
        dir    = d;
        start  = 1'b1;
        if (w != 0 && h != 0) push_op(w, h, dg, d);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (w != 0 && h != 0) op_active = 1'b1;
        budget = 40 * w * h + 100;
        n = 0;
        while ((op_active || expect_idle) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            width  = 16'($urandom_range(1, 40));
            height = 16'($urandom_range(1, 40));
            deg    = 3'($urandom_range(7));
            dir    = 1'($urandom_range(1));
            start  = poke && (n == 5);
            if (reset_at > 0 && n == reset_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("async_reset_outputs", {busy, addr, wr, count, size}, 64'd0);
                exp_q.delete();
                op_active   = 1'b0;
                expect_idle = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        if (op_active || expect_idle) begin
            checks++;
            $display("FAIL timeout w=%0d h=%0d remaining=%0d required=0", w, h, exp_q.size());
            exp_q.delete();
            op_active   = 1'b0;
            expect_idle = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        width  = 16'd0;
        height = 16'd0;
        dir    = 1'b0;
        deg    = 3'd0;
        #2;
        check("reset_state", {busy, addr, wr, count, size}, 64'd0);
        #20;
        rst_n = 1'b1;

        run_op(8, 8, 0, 1'b0, 100, 1'b0, 0);
        run_op(62, 63, 0, 1'b0, 95, 1'b0, 0);
        run_op(123, 5, 0, 1'b0, 80, 1'b0, 0);
        run_op(32, 24, 1, 1'b0, 100, 1'b0, 0);
        run_op(32, 24, 1, 1'b1, 60, 1'b1, 0);
        run_op(0, 9, 0, 1'b0, 100, 1'b0, 0);
        run_op(9, 0, 2, 1'b0, 100, 1'b0, 0);
        run_op(10, 7, 6, 1'b0, 50, 1'b1, 0);
        run_op(16, 16, 2, 1'b0, 100, 1'b0, 3);
        run_op(5, 6, 3, 1'b0, 70, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            run_op($urandom_range(1, 14), $urandom_range(1, 14), $urandom_range(7),
                   1'($urandom_range(1)), $urandom_range(30, 100), 1'($urandom_range(1)), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
